// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: ALU control decode, operand select, load-use bubble insertion.
// Define ID_EX_FWD_EN to add EX/MEM and MEM/WB forwarding muxes on the registered operands.
module id_ex_stage #(
  parameter int unsigned word_size = 32,
  parameter int unsigned reg_bits  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [word_size-1:0] id_rs_data,
  input  logic [word_size-1:0] id_rt_data,
  input  logic [word_size-1:0] id_imm,
  input  logic [reg_bits-1:0]  id_rs,
  input  logic [reg_bits-1:0]  id_rt,
  input  logic [reg_bits-1:0]  id_rd,
  input  logic [1:0]           id_alu_op,
  input  logic [5:0]           id_funct,
  input  logic                 id_alu_src,
  input  logic                 id_reg_dst,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 id_mem_to_reg,
`ifdef ID_EX_FWD_EN
  input  logic                 mem_fwd_we,
  input  logic [reg_bits-1:0]  mem_fwd_reg,
  input  logic [word_size-1:0] mem_fwd_data,
  input  logic                 wb_fwd_we,
  input  logic [reg_bits-1:0]  wb_fwd_reg,
  input  logic [word_size-1:0] wb_fwd_data,
`endif
  output logic                 hazard_stall,
  output logic                 ex_valid,
  output logic [3:0]           ex_alu_ctrl,
  output logic [word_size-1:0] ex_data1,
  output logic [word_size-1:0] ex_data2,
  output logic [word_size-1:0] ex_store_data,
  output logic [reg_bits-1:0]  ex_write_reg,
  output logic [reg_bits-1:0]  ex_rs,
  output logic [reg_bits-1:0]  ex_rt,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_mem_to_reg,
  output logic                 ex_illegal
);

  logic                 valid_q, alu_src_q, reg_write_q, mem_read_q, mem_write_q;
  logic                 mem_to_reg_q, illegal_q;
  logic [3:0]           alu_ctrl_q;
  logic [word_size-1:0] rs_data_q, rt_data_q, imm_q;
  logic [reg_bits-1:0]  write_reg_q, rs_q, rt_q;

  logic [3:0]           alu_code;
  logic                 illegal;
  logic                 bubble;
  logic [word_size-1:0] rs_val, rt_val;

  always_comb begin
    alu_code = 4'b0010;
    illegal  = 1'b0;
    unique case (id_alu_op)
      2'b00: alu_code = 4'b0010;
      2'b01: alu_code = 4'b0110;
      2'b10: begin
        case (id_funct)
          6'b100000: alu_code = 4'b0010;
          6'b100010: alu_code = 4'b0110;
          6'b100100: alu_code = 4'b0000;
          6'b100101: alu_code = 4'b0001;
          6'b100111: alu_code = 4'b1100;
          6'b101010: alu_code = 4'b0111;
          default:   illegal  = 1'b1;
        endcase
      end
      2'b11: illegal = 1'b1;
    endcase
  end

  // Load-use: the load in EX cannot supply its value in time for the consumer in ID.
  assign hazard_stall = valid_q & mem_read_q & (write_reg_q != '0) & id_valid &
                        ((write_reg_q == id_rs) | (write_reg_q == id_rt)) & ~flush;

  // rst and flush beat stall; a hazard bubble only lands when the stage is not held.
  assign bubble = rst | flush | (~stall & hazard_stall);

  always_ff @(posedge clk) begin
    if (bubble) begin
      valid_q      <= 1'b0;
      alu_ctrl_q   <= 4'b0000;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      alu_src_q    <= 1'b0;
      write_reg_q  <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (!stall) begin
      valid_q      <= id_valid;
      alu_ctrl_q   <= alu_code;
      rs_data_q    <= id_rs_data;
      rt_data_q    <= id_rt_data;
      imm_q        <= id_imm;
      alu_src_q    <= id_alu_src;
      write_reg_q  <= id_reg_dst ? id_rd : id_rt;
      rs_q         <= id_rs;
      rt_q         <= id_rt;
      reg_write_q  <= id_reg_write & id_valid;
      mem_read_q   <= id_mem_read & id_valid;
      mem_write_q  <= id_mem_write & id_valid;
      mem_to_reg_q <= id_mem_to_reg & id_valid;
      illegal_q    <= illegal & id_valid;
    end
  end

`ifdef ID_EX_FWD_EN
  // The younger result (EX/MEM) wins over MEM/WB; r0 is never forwarded.
  always_comb begin
    rs_val = rs_data_q;
    rt_val = rt_data_q;
    if (mem_fwd_we && mem_fwd_reg != '0 && mem_fwd_reg == rs_q) begin
      rs_val = mem_fwd_data;
    end else if (wb_fwd_we && wb_fwd_reg != '0 && wb_fwd_reg == rs_q) begin
      rs_val = wb_fwd_data;
    end
    if (mem_fwd_we && mem_fwd_reg != '0 && mem_fwd_reg == rt_q) begin
      rt_val = mem_fwd_data;
    end else if (wb_fwd_we && wb_fwd_reg != '0 && wb_fwd_reg == rt_q) begin
      rt_val = wb_fwd_data;
    end
  end
`else
  assign rs_val = rs_data_q;
  assign rt_val = rt_data_q;
`endif

  assign ex_valid      = valid_q;
  assign ex_alu_ctrl   = alu_ctrl_q;
  assign ex_data1      = rs_val;
  assign ex_data2      = alu_src_q ? imm_q : rt_val;
  assign ex_store_data = rt_val;
  assign ex_write_reg  = write_reg_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents queued per edge and compared after it.
module tb_id_ex_stage;

  logic        clk, rst, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        mem_fwd_we, wb_fwd_we;
  logic [4:0]  mem_fwd_reg, wb_fwd_reg;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        hazard_stall, ex_valid;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_data1, ex_data2, ex_store_data;
  logic [4:0]  ex_write_reg, ex_rs, ex_rt;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;

  id_ex_stage #(.word_size(32), .reg_bits(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
`ifdef ID_EX_FWD_EN
    .mem_fwd_we(mem_fwd_we), .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_reg(wb_fwd_reg), .wb_fwd_data(wb_fwd_data),
`endif
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic [31:0] d1, d2, st;
    logic [4:0]  wr, rs, rt;
    logic        rw, mr, mw, m2r, ill;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode of what the next edge should load from the ID inputs.
  function automatic exp_t model();
    exp_t e;
    e.ill = 1'b0;
    case (id_alu_op)
      2'b00: e.alu = 4'b0010;
      2'b01: e.alu = 4'b0110;
      2'b10: begin
        case (id_funct)
          6'h20: e.alu = 4'b0010;
          6'h22: e.alu = 4'b0110;
          6'h24: e.alu = 4'b0000;
          6'h25: e.alu = 4'b0001;
          6'h27: e.alu = 4'b1100;
          6'h2a: e.alu = 4'b0111;
          default: begin e.alu = 4'b0010; e.ill = 1'b1; end
        endcase
      end
      default: begin e.alu = 4'b0010; e.ill = 1'b1; end
    endcase
    e.ill   = e.ill & id_valid;
    e.valid = id_valid;
    e.d1    = id_rs_data;
    e.d2    = id_alu_src ? id_imm : id_rt_data;
    e.st    = id_rt_data;
    e.wr    = id_reg_dst ? id_rd : id_rt;
    e.rs    = id_rs;
    e.rt    = id_rt;
    e.rw    = id_reg_write & id_valid;
    e.mr    = id_mem_read & id_valid;
    e.mw    = id_mem_write & id_valid;
    e.m2r   = id_mem_to_reg & id_valid;
    return e;
  endfunction

  task automatic push_load();
    last = model();
    sb.push_back(last);
  endtask

  task automatic push_zero();
    last = '0;
    sb.push_back(last);
  endtask

  task automatic push_hold();
    sb.push_back(last);
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".valid"}, ex_valid, e.valid);
      chk({tag, ".alu"}, ex_alu_ctrl, e.alu);
      chk({tag, ".d1"}, ex_data1, e.d1);
      chk({tag, ".d2"}, ex_data2, e.d2);
      chk({tag, ".st"}, ex_store_data, e.st);
      chk({tag, ".wr"}, ex_write_reg, e.wr);
      chk({tag, ".rs"}, ex_rs, e.rs);
      chk({tag, ".rt"}, ex_rt, e.rt);
      chk({tag, ".rw"}, ex_reg_write, e.rw);
      chk({tag, ".mr"}, ex_mem_read, e.mr);
      chk({tag, ".mw"}, ex_mem_write, e.mw);
      chk({tag, ".m2r"}, ex_mem_to_reg, e.m2r);
      chk({tag, ".ill"}, ex_illegal, e.ill);
    end
  endtask

  task automatic set_instr(input logic v, input logic [1:0] op, input logic [5:0] fn,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                           input logic asrc, input logic rdst, input logic rw, input logic mr,
                           input logic mw, input logic m2r);
    id_valid = v;     id_alu_op = op;    id_funct = fn;
    id_rs = rs;       id_rt = rt;        id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd;  id_imm = imm;
    id_alu_src = asrc; id_reg_dst = rdst; id_reg_write = rw;
    id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  initial begin
    logic [5:0] functs [5];
    functs = '{6'h20, 6'h24, 6'h25, 6'h27, 6'h2a};
    stall = 0; flush = 0; rst = 1;
    mem_fwd_we = 0; mem_fwd_reg = 0; mem_fwd_data = 0;
    wb_fwd_we = 0; wb_fwd_reg = 0; wb_fwd_data = 0;

    // Reset with a valid instruction presented
    set_instr(1, 2'b10, 6'h20, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 1, 1, 1, 1, 1);
    push_zero(); step("reset");
    chk("reset.hazard", hazard_stall, 1'b0);
    rst = 0;

    // R-type sub, then unknown funct
    set_instr(1, 2'b10, 6'h22, 1, 2, 3, 32'd9, 32'd4, 32'h0, 0, 1, 1, 0, 0, 0);
    push_load(); step("sub");
    chk("sub.code", ex_alu_ctrl, 4'b0110);
    id_funct = 6'h3f;
    push_load(); step("badfn");
    chk("badfn.ill", ex_illegal, 1'b1);
    for (int i = 0; i < 5; i++) begin
      id_funct = functs[i]; id_rs_data = 32'(i * 7 + 1);
      push_load(); step("rtype");
    end
    id_alu_op = 2'b11;
    push_load(); step("op11");
    id_valid = 0; id_funct = 6'h3f; id_alu_op = 2'b10;
    push_load(); step("invalid");

    // addi with all-ones immediate, rt destination
    set_instr(1, 2'b00, 6'h00, 4, 7, 9, 32'h5, 32'h6, 32'hffffffff, 1, 0, 1, 0, 0, 0);
    push_load(); step("addi");
    chk("addi.d2", ex_data2, 32'hffffffff);
    chk("addi.wr", ex_write_reg, 5'd7);

    // Load-use hazard
    set_instr(1, 2'b00, 6'h00, 2, 5, 0, 32'h100, 32'h0, 32'h8, 1, 0, 1, 1, 0, 1);
    push_load(); step("lw");
    set_instr(1, 2'b10, 6'h20, 5, 6, 8, 32'h1, 32'h2, 32'h0, 0, 1, 1, 0, 0, 0);
    #1 chk("lu.hazard", hazard_stall, 1'b1);
    push_zero(); step("lu.bubble");
    chk("lu.clear", hazard_stall, 1'b0);
    push_load(); step("lu.load");

    // Load to r0 never stalls; invalid consumer never stalls
    set_instr(1, 2'b00, 6'h00, 2, 0, 0, 32'h100, 32'h0, 32'h8, 1, 0, 1, 1, 0, 1);
    push_load(); step("lw0");
    set_instr(1, 2'b10, 6'h20, 0, 0, 8, 32'h1, 32'h2, 32'h0, 0, 1, 1, 0, 0, 0);
    #1 chk("r0.hazard", hazard_stall, 1'b0);
    set_instr(1, 2'b00, 6'h00, 2, 5, 0, 32'h100, 32'h0, 32'h8, 1, 0, 1, 1, 0, 1);
    push_load(); step("lw5");
    set_instr(0, 2'b10, 6'h20, 7, 5, 8, 32'h1, 32'h2, 32'h0, 0, 1, 1, 0, 0, 0);
    #1 chk("inv.hazard", hazard_stall, 1'b0);

    // Stall together with hazard: hold, then bubble once released
    set_instr(1, 2'b10, 6'h20, 7, 5, 8, 32'h1, 32'h2, 32'h0, 0, 1, 1, 0, 0, 0);
    stall = 1;
    #1 chk("sh.hazard", hazard_stall, 1'b1);
    push_hold(); step("sh.hold");
    stall = 0;
    push_zero(); step("sh.bubble");
    push_load(); step("sh.load");

    // Three-cycle stall holds everything while ID changes
    set_instr(1, 2'b01, 6'h00, 3, 4, 5, 32'hdead, 32'hbeef, 32'h7, 0, 0, 1, 0, 1, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_rs_data = 32'(i); id_alu_op = 2'(i);
      push_hold(); step("stall");
    end
    stall = 0;

    // Flush with stall turns a held load into a bubble, suppressing the hazard
    set_instr(1, 2'b00, 6'h00, 2, 5, 0, 32'h100, 32'h0, 32'h8, 1, 0, 1, 1, 0, 1);
    push_load(); step("lw.f");
    set_instr(1, 2'b10, 6'h20, 5, 6, 8, 32'h1, 32'h2, 32'h0, 0, 1, 1, 0, 0, 0);
    stall = 1; flush = 1;
    #1 chk("flush.hazard", hazard_stall, 1'b0);
    push_zero(); step("flush");
    stall = 0; flush = 0;
    push_load(); step("after.flush");

`ifdef ID_EX_FWD_EN
    set_instr(1, 2'b10, 6'h20, 3, 4, 8, 32'h11, 32'h22, 32'h0, 0, 1, 1, 0, 0, 0);
    push_load(); step("fwd.load");
    mem_fwd_we = 1; mem_fwd_reg = 3; mem_fwd_data = 32'haa;
    wb_fwd_we = 1; wb_fwd_reg = 3; wb_fwd_data = 32'hbb;
    #1 chk("fwd.mem", ex_data1, 32'haa);
    mem_fwd_reg = 0;
    #1 chk("fwd.wb", ex_data1, 32'hbb);
    wb_fwd_reg = 4;
    #1 chk("fwd.rt", ex_data2, 32'hbb);
    chk("fwd.st", ex_store_data, 32'hbb);
    chk("fwd.none", ex_data1, 32'h11);
    wb_fwd_we = 0; mem_fwd_we = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
